// File: rtl/sched_pkg.sv
// Shared types for the vadd job scheduler: job descriptor and FSM state.
// No ports. Localparam widths match the top-level parameter defaults.
package sched_pkg;

  localparam int SCHED_ADDR_W = 13;
  localparam int SCHED_LEN_W  = 32;

  typedef struct packed {
    logic [SCHED_ADDR_W-1:0] addr_a;
    logic [SCHED_ADDR_W-1:0] addr_b;
    logic [SCHED_ADDR_W-1:0] addr_out;
    logic [SCHED_LEN_W-1:0]  len;
  } job_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sched_desc_fifo.sv
// Synchronous descriptor FIFO holding job_t entries.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, data_i    write request and descriptor (ignored when full or flushing)
//   pop_i             read request (ignored when empty or flushing)
//   flush_i           drop every stored entry at the next edge
//   data_o            head entry (valid when not empty)
//   count_o           occupancy, full_o / empty_o status
module sched_desc_fifo
  import sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  job_t                   data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output job_t                   data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  job_t        mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o && !flush_i;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      rd_d = wr_q;
    end else begin
      if (do_push)            wr_d = wr_q + 1'b1;
      if (pop_i && !empty_o)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/vadd_job_scheduler.sv
// Command front-end for the vadd compute engine. Queues job descriptors,
// launches the engine one job at a time and drops zero-length jobs.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   job_valid/job_ready        descriptor handshake; job_addr_a/b/out, job_len fields
//   flush                      discard queued (not in-flight) descriptors
//   cu_start, cu_addr_*/cu_len one-cycle engine start and held operands
//   cu_done                    engine completion pulse
//   busy, pending              activity flag and FIFO occupancy
//   jobs_done, jobs_dropped    wrapping completion / drop counters
//   busy_cycles                saturating RUN-cycle counter, present only when
//                              SCHED_PERF_EN is defined
module vadd_job_scheduler
  import sched_pkg::*;
#(
  parameter int ADDR_WIDTH = SCHED_ADDR_W,
  parameter int LEN_WIDTH  = SCHED_LEN_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [ADDR_WIDTH-1:0]         job_addr_a,
  input  logic [ADDR_WIDTH-1:0]         job_addr_b,
  input  logic [ADDR_WIDTH-1:0]         job_addr_out,
  input  logic [LEN_WIDTH-1:0]          job_len,
  input  logic                          flush,
  output logic                          cu_start,
  output logic [ADDR_WIDTH-1:0]         cu_addr_a,
  output logic [ADDR_WIDTH-1:0]         cu_addr_b,
  output logic [ADDR_WIDTH-1:0]         cu_addr_out,
  output logic [LEN_WIDTH-1:0]          cu_len,
  input  logic                          cu_done,
`ifdef SCHED_PERF_EN
  output logic [31:0]                   busy_cycles,
`endif
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic [CNT_WIDTH-1:0]          jobs_done,
  output logic [CNT_WIDTH-1:0]          jobs_dropped
);

  sched_state_t         state_q, state_d;
  job_t                 op_q, op_d;
  logic                 start_q, start_d;
  logic [CNT_WIDTH-1:0] done_cnt_q, done_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  job_t fifo_in, fifo_head;
  logic fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign fifo_in.addr_a   = job_addr_a;
  assign fifo_in.addr_b   = job_addr_b;
  assign fifo_in.addr_out = job_addr_out;
  assign fifo_in.len      = job_len;

  // Ready uses the pre-pop count, and a flush refuses the same-cycle push.
  assign job_ready = !fifo_full && !flush;
  assign fifo_push = job_valid && job_ready;

  sched_desc_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .data_i (fifo_in),
    .pop_i  (fifo_pop),
    .flush_i(flush),
    .data_o (fifo_head),
    .count_o(pending),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    start_d    = 1'b0;
    done_cnt_d = done_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush discards the head too, so no pop that cycle.
        if (!fifo_empty && !flush) begin
          fifo_pop = 1'b1;
          op_d     = fifo_head;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (op_q.len == '0) begin
          drop_cnt_d = drop_cnt_q + 1'b1;
          state_d    = IDLE;
        end else begin
          start_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cu_done) begin
          done_cnt_d = done_cnt_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      start_q    <= 1'b0;
      done_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      start_q    <= start_d;
      done_cnt_q <= done_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign cu_start     = start_q;
  assign cu_addr_a    = op_q.addr_a;
  assign cu_addr_b    = op_q.addr_b;
  assign cu_addr_out  = op_q.addr_out;
  assign cu_len       = op_q.len;
  assign busy         = (state_q != IDLE) || (pending != '0);
  assign jobs_done    = done_cnt_q;
  assign jobs_dropped = drop_cnt_q;

`ifdef SCHED_PERF_EN
  logic [31:0] busy_cyc_q, busy_cyc_d;

  always_comb begin
    busy_cyc_d = busy_cyc_q;
    if (state_q == RUN && busy_cyc_q != '1) busy_cyc_d = busy_cyc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cyc_q <= '0;
    else        busy_cyc_q <= busy_cyc_d;
  end

  assign busy_cycles = busy_cyc_q;
`endif

endmodule
